// File: rtl/tiny_riscv_prog_loader.sv
// Program loader for the tiny RISC-V core: receives a LEN/data/CHK frame over a nibble link,
// writes the bytes into the instruction RAM and releases the core only after the checksum matches.
module tiny_riscv_prog_loader #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_ld_start,
  input  logic                  i_nib_valid,
  input  logic [3:0]            i_nib_data,
  output logic                  o_nib_ready,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic                  o_core_hold,
  output logic                  o_ld_busy,
  output logic                  o_ld_done,
  output logic                  o_ld_err,
  output logic [ADDR_WIDTH:0]   o_word_count
);
  localparam int                TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]        MAX_LEN  = 8'(2 ** ADDR_WIDTH);
  localparam logic [TW-1:0]     TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH:0] WC_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR    = 3'd1,
    S_DATA   = 3'd2,
    S_WRITE  = 3'd3,
    S_CHK    = 3'd4,
    S_VERIFY = 3'd5,
    S_DONE   = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_phase;
  logic [3:0]            r_hi;
  logic [ADDR_WIDTH:0]   r_len;
  logic [7:0]            r_acc;
  logic [7:0]            r_chk;
  logic [TW-1:0]         r_timer;
  logic                  r_nib_ready;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_hold;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;
  logic [ADDR_WIDTH:0]   r_wc;

  logic                  w_rx;
  logic                  w_xfer;
  logic                  w_lo_xfer;
  logic                  w_tmo;
  logic                  w_start;
  logic [7:0]            w_byte;
  logic [ADDR_WIDTH:0]   w_wc_inc;

  assign w_rx      = (r_state == S_HDR) || (r_state == S_DATA) || (r_state == S_CHK);
  assign w_xfer    = i_nib_valid & r_nib_ready;
  assign w_lo_xfer = w_xfer & r_phase;
  assign w_tmo     = w_rx & ~w_xfer & (r_timer == TMO_LAST);
  assign w_start   = i_ld_start &
                     ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR));
  assign w_byte    = {r_hi, i_nib_data};
  assign w_wc_inc  = r_wc + WC_ONE;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (w_start) w_state_nxt = S_HDR;
        else         w_state_nxt = r_state;
      end
      S_HDR: begin
        if (w_tmo)                                         w_state_nxt = S_ERROR;
        else if (w_lo_xfer && (w_byte == 8'd0 || w_byte > MAX_LEN)) w_state_nxt = S_ERROR;
        else if (w_lo_xfer)                                w_state_nxt = S_DATA;
        else                                               w_state_nxt = S_HDR;
      end
      S_DATA: begin
        if (w_tmo)          w_state_nxt = S_ERROR;
        else if (w_lo_xfer) w_state_nxt = S_WRITE;
        else                w_state_nxt = S_DATA;
      end
      S_WRITE: begin
        if (w_wc_inc < r_len) w_state_nxt = S_DATA;
        else                  w_state_nxt = S_CHK;
      end
      S_CHK: begin
        if (w_tmo)          w_state_nxt = S_ERROR;
        else if (w_lo_xfer) w_state_nxt = S_VERIFY;
        else                w_state_nxt = S_CHK;
      end
      S_VERIFY: begin
        if (r_chk == r_acc) w_state_nxt = S_DONE;
        else                w_state_nxt = S_ERROR;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath and registered outputs; status flags follow the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase     <= 1'b0;
      r_hi        <= 4'd0;
      r_len       <= '0;
      r_acc       <= 8'd0;
      r_chk       <= 8'd0;
      r_timer     <= '0;
      r_nib_ready <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_hold      <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_wc        <= '0;
    end else begin
      r_nib_ready <= (w_state_nxt == S_HDR) || (w_state_nxt == S_DATA) || (w_state_nxt == S_CHK);
      r_we        <= (w_state_nxt == S_WRITE);
      r_hold      <= (w_state_nxt != S_DONE);
      r_busy      <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE) &&
                     (w_state_nxt != S_ERROR);

      if (!w_rx)       r_timer <= '0;
      else if (w_xfer) r_timer <= '0;
      else             r_timer <= r_timer + TW'(1);

      if (w_xfer) begin
        r_phase <= ~r_phase;
        if (!r_phase) r_hi <= i_nib_data;
      end

      if (r_state == S_VERIFY && w_state_nxt == S_DONE) r_done <= 1'b1;
      if (w_state_nxt == S_ERROR && r_state != S_ERROR) r_err <= 1'b1;

      case (r_state)
        S_HDR: begin
          if (w_lo_xfer) r_len <= w_byte[ADDR_WIDTH:0];
        end
        S_DATA: begin
          if (w_lo_xfer) begin
            r_wdata <= DATA_WIDTH'(w_byte);
            r_addr  <= r_wc[ADDR_WIDTH-1:0];
            r_acc   <= r_acc + w_byte;
          end
        end
        S_WRITE: r_wc <= w_wc_inc;
        S_CHK: begin
          if (w_lo_xfer) r_chk <= w_byte;
        end
        default: ;
      endcase

      // A new frame wipes the previous frame's status and accumulators
      if (w_start) begin
        r_done  <= 1'b0;
        r_err   <= 1'b0;
        r_wc    <= '0;
        r_acc   <= 8'd0;
        r_timer <= '0;
        r_phase <= 1'b0;
      end
    end
  end

  assign o_nib_ready  = r_nib_ready;
  assign o_mem_we     = r_we;
  assign o_mem_addr   = r_addr;
  assign o_mem_wdata  = r_wdata;
  assign o_core_hold  = r_hold;
  assign o_ld_busy    = r_busy;
  assign o_ld_done    = r_done;
  assign o_ld_err     = r_err;
  assign o_word_count = r_wc;

endmodule
